vscpu_mem_responder: RTL



---
 rtl/vscpu_pkg.sv | 36 +++
 rtl/vscpu_out_fifo.sv | 58 +++++
 rtl/vscpu_mem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vscpu_pkg.sv
// rtl/vscpu_pkg.sv - shared types and constants for the VSCPU memory responder and CPU
package vscpu_pkg;

    // Responder operating mode: host loading RAM, or CPU running
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int         SIZE_DEFAULT    = 14;
    localparam logic [13:0] IO_ADDR_DEFAULT = 14'h3FFF;

    // Status word layout returned on reads of the IO address
    localparam int OVF_BIT = 3;
    localparam int CNT_MSB = 2;

    // VerySimpleCPU opcodes (bit 28 of the instruction selects the immediate form)
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_LT   = 3'd3;
    localparam logic [2:0] OP_CP   = 3'd4;
    localparam logic [2:0] OP_CPI  = 3'd5;
    localparam logic [2:0] OP_BZJ  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    // Builds the IO status word from the sticky overflow flag and FIFO occupancy
    function automatic logic [31:0] status_word(input logic ovf, input logic [CNT_MSB:0] cnt);
        logic [31:0] w;
        w              = '0;
        w[OVF_BIT]     = ovf;
        w[CNT_MSB:0]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/vscpu_out_fifo.sv
// rtl/vscpu_out_fifo.sv - small synchronous FIFO carrying CPU output words to the host
module vscpu_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : buf_q[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (do_push && !clear) buf_q[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vscpu_mem_responder.sv
// rtl/vscpu_mem_responder.sv - VSCPU RAM, host loader and memory-mapped output FIFO
module vscpu_mem_responder
    import vscpu_pkg::*;
#(
    parameter int               SIZE       = 14,
    parameter int               MEM_WORDS  = 16384,
    parameter logic [SIZE-1:0]  IO_ADDR    = IO_ADDR_DEFAULT,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrEn,
    input  logic [SIZE-1:0] addr_toRAM,
    input  logic [31:0]     data_toRAM,
    output logic [31:0]     data_fromRAM,
    output logic            cpu_rst,
    input  logic            ld_start,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [SIZE-1:0] ld_addr,
    input  logic [31:0]     ld_data,
    input  logic            ld_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic              fifo_clear;
    logic              overflow_q;
    logic              cpu_active;
    logic              io_hit;
    logic              io_push;
    logic              ld_fire;
    logic              ram_we;
    logic [SIZE-1:0]   ram_waddr;
    logic [31:0]       ram_wdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       fifo_head;
    logic              fifo_pop;

    logic [31:0]       mem [MEM_WORDS];

    // Mode register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= LOAD;
        else      state_q <= state_d;
    end

    // Mode transitions and the CPU/loader control outputs
    always_comb begin
        state_d    = state_q;
        cpu_rst    = 1'b1;
        ld_ready   = 1'b0;
        fifo_clear = 1'b0;
        case (state_q)
            LOAD: begin
                cpu_rst  = 1'b1;
                ld_ready = 1'b1;
                if (ld_valid && ld_last) state_d = LOAD == LOAD ? RUN : LOAD;
            end
            RUN: begin
                cpu_rst    = 1'b0;
                ld_ready   = 1'b0;
                fifo_clear = ld_start;
                if (ld_start) state_d = LOAD;
            end
        endcase
    end

    assign cpu_active = (state_q == RUN);
    assign io_hit     = (addr_toRAM == IO_ADDR);
    assign io_push    = cpu_active && wrEn && io_hit;
    assign ld_fire    = ld_valid && ld_ready;
    assign fifo_pop   = out_valid && out_ready;

    // Loader and CPU never write in the same mode, so one write port serves both
    assign ram_we    = ld_fire ? (ld_addr != IO_ADDR) : (cpu_active && wrEn && !io_hit);
    assign ram_waddr = ld_fire ? ld_addr : addr_toRAM;
    assign ram_wdata = ld_fire ? ld_data : data_toRAM;

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    // Registered read: old RAM contents on a same-address write, status word at IO_ADDR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_fromRAM <= '0;
        end else if (!cpu_active) begin
            data_fromRAM <= '0;
        end else if (io_hit) begin
            data_fromRAM <= status_word(overflow_q, (CNT_MSB+1)'(fifo_count));
        end else begin
            data_fromRAM <= mem[addr_toRAM];
        end
    end

    // Sticky overflow: an IO write found the FIFO full with no pop to make room
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (fifo_clear) begin
            overflow_q <= 1'b0;
        end else if (io_push && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    vscpu_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (fifo_clear),
        .push      (io_push),
        .push_data (data_toRAM),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;

endmodule
